// File: rtl/iomem_dma_pkg.sv
// Shared types and constants for the iomem word-copy engine.
package iomem_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RGAP,
    ST_WR,
    ST_WGAP,
    ST_FIN
  } dma_state_e;

  localparam logic [3:0] WSTRB_READ = 4'h0;
  localparam logic [3:0] WSTRB_WORD = 4'hF;
  localparam int         WORD_BYTES = 4;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/iomem_dma_if.sv
// picosoc iomem bus bundle; the DMA engine is the master, memory-mapped responders the slave.
// Handshake: a transfer completes on a clock edge where iomem_valid and iomem_ready are both high;
// addr/wstrb/wdata hold steady while iomem_valid is high, and iomem_rdata is only meaningful with iomem_ready.
interface iomem_dma_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    input  iomem_ready, iomem_rdata
  );

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    output iomem_ready, iomem_rdata
  );
endinterface

// File: rtl/iomem_dma_timer.sv
// Wait counter for an outstanding bus request; expired_o flags the last tolerated ready-less cycle.
module iomem_dma_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q counts ready-less cycles already completed, so the TIMEOUT_CYCLES-th one is cnt_q == T-1.
  assign expired_o = en_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/iomem_dma.sv
// Word-copy initiator on the picosoc iomem bus: reads len words from src, writes each to dst.
module iomem_dma
  import iomem_dma_pkg::*;
#(
  parameter int LEN_W          = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [31:0]       src_addr,
  input  logic [31:0]       dst_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [LEN_W-1:0]  count,
  output dma_state_e        dbg_state,
  iomem_dma_if.master       bus
);

  dma_state_e       state_q, state_d;
  logic [31:0]      src_q, src_d, dst_q, dst_d;
  logic [LEN_W-1:0] len_q, len_d, count_q, count_d;
  logic [31:0]      addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic             valid_q, valid_d, busy_q, busy_d;
  logic             done_q, done_d, error_q, error_d;
  logic             in_req, expired;

  assign in_req = (state_q == ST_RD) || (state_q == ST_WR);

  iomem_dma_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk       (clk),
    .resetn    (resetn),
    .clr_i     (!in_req),
    .en_i      (in_req && !bus.iomem_ready),
    .expired_o (expired)
  );

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    count_d = count_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    error_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          count_d = '0;
          if (len != '0) begin
            src_d   = word_align(src_addr);
            dst_d   = word_align(dst_addr);
            len_d   = len;
            state_d = ST_RD;
          end else begin
            state_d = ST_FIN;
          end
        end
      end
      ST_RD: begin
        if (bus.iomem_ready) begin
          wdata_d = bus.iomem_rdata;
          state_d = ST_RGAP;
        end else if (expired) begin
          error_d = 1'b1;
          state_d = ST_FIN;
        end
      end
      ST_RGAP: state_d = ST_WR;
      ST_WR: begin
        if (bus.iomem_ready) begin
          count_d = count_q + LEN_W'(1);
          src_d   = src_q + 32'(WORD_BYTES);
          dst_d   = dst_q + 32'(WORD_BYTES);
          state_d = ST_WGAP;
        end else if (expired) begin
          error_d = 1'b1;
          state_d = ST_FIN;
        end
      end
      ST_WGAP: state_d = (count_q == len_q) ? ST_FIN : ST_RD;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Bus outputs are decoded from the next state so they appear registered in the request cycle.
    valid_d = (state_d == ST_RD) || (state_d == ST_WR);
    wstrb_d = (state_d == ST_WR) ? WSTRB_WORD : WSTRB_READ;
    if (state_d == ST_RD) begin
      addr_d = src_d;
    end else if (state_d == ST_WR) begin
      addr_d = dst_d;
    end
    busy_d = (state_d == ST_RD) || (state_d == ST_RGAP) ||
             (state_d == ST_WR) || (state_d == ST_WGAP);
    done_d = (state_d == ST_FIN);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      count_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= WSTRB_READ;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign error           = error_q;
  assign count           = count_q;
  assign dbg_state       = state_q;
  assign bus.iomem_valid = valid_q;
  assign bus.iomem_wstrb = wstrb_q;
  assign bus.iomem_addr  = addr_q;
  assign bus.iomem_wdata = wdata_q;

endmodule

// File: tb/tb_iomem_dma.sv
// Directed bench for iomem_dma: responder model on the iomem bus, transaction log vs expected queue.
module tb_iomem_dma;
  import iomem_dma_pkg::*;

  localparam int LEN_W = 16;
  localparam int TMO   = 8;

  logic             clk = 1'b0;
  logic             resetn;
  logic             start;
  logic [31:0]      src_addr, dst_addr;
  logic [LEN_W-1:0] len;
  logic             busy, done, error;
  logic [LEN_W-1:0] count;
  dma_state_e       dbg_state;

  iomem_dma_if bus();

  iomem_dma #(.LEN_W(LEN_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .count     (count),
    .dbg_state (dbg_state),
    .bus       (bus)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- responder model ----------------
  int          wait_n;
  logic        rand_wait;
  logic [31:0] stall_addr;
  logic [67:0] obs [0:255];
  int          obs_n = 0;
  int          wcnt = 0;
  int          cur_wait = 0;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
  endfunction

  always @(negedge clk) begin
    if (!resetn) begin
      bus.iomem_ready = 1'b0;
      bus.iomem_rdata = 32'hBAD0_BAD0;
      wcnt = 0;
    end else if (bus.iomem_ready) begin
      bus.iomem_ready = 1'b0;
      bus.iomem_rdata = 32'hBAD0_BAD0;
    end else if (bus.iomem_valid &&
                 !(bus.iomem_wstrb == 4'h0 && bus.iomem_addr == stall_addr)) begin
      if (wcnt == 0) cur_wait = rand_wait ? int'($urandom_range(0, 5)) : wait_n;
      if (wcnt >= cur_wait) begin
        bus.iomem_ready = 1'b1;
        bus.iomem_rdata = pat(bus.iomem_addr);
        obs[obs_n % 256] = {bus.iomem_wstrb, bus.iomem_addr,
                            (bus.iomem_wstrb != 4'h0) ? bus.iomem_wdata : 32'h0};
        obs_n++;
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int          n_total = 0;
  int          n_bad   = 0;
  logic [67:0] exp_q[$];
  int          rd_ptr  = 0;

  task automatic chk(input string tag, input logic [67:0] got, input logic [67:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push_copy(input logic [31:0] s, input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({4'h0, s + 32'(4 * i), 32'h0});
      exp_q.push_back({4'hF, d + 32'(4 * i), pat(s + 32'(4 * i))});
    end
  endtask

  task automatic check_log();
    chk("txn_count", 68'(obs_n - rd_ptr), 68'(exp_q.size()));
    while (exp_q.size() > 0 && rd_ptr < obs_n) begin
      chk("txn", obs[rd_ptr % 256], exp_q.pop_front());
      rd_ptr++;
    end
    exp_q.delete();
    rd_ptr = obs_n;
  endtask

  // ---------------- driver ----------------
  int          done_cyc, vcnt;
  logic        first_busy, first_valid, busy_seen, err_at_done, busy_at_done;
  logic [LEN_W-1:0] cnt_at_done;
  logic        prev_v;
  logic [31:0] hold_addr, hold_wdata;
  logic [3:0]  hold_wstrb;

  task automatic run_job(input logic [31:0] s, input logic [31:0] d,
                         input logic [LEN_W-1:0] l, input int inj);
    @(negedge clk);
    start = 1'b1; src_addr = s; dst_addr = d; len = l;
    @(posedge clk);
    done_cyc = -1; vcnt = 0; busy_seen = 1'b0; prev_v = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      start = (c == inj);
      if (c == inj) begin
        src_addr = 32'h0BAD_0000; dst_addr = 32'h0BAD_1000; len = LEN_W'(1);
      end
      if (c == 1) begin
        first_busy = busy; first_valid = bus.iomem_valid;
      end
      if (busy) busy_seen = 1'b1;
      if (bus.iomem_valid) begin
        vcnt++;
        if (prev_v) begin
          chk("stable_addr", 68'(bus.iomem_addr), 68'(hold_addr));
          chk("stable_wstrb", 68'(bus.iomem_wstrb), 68'(hold_wstrb));
          chk("stable_wdata", 68'(bus.iomem_wdata), 68'(hold_wdata));
        end
        hold_addr = bus.iomem_addr; hold_wstrb = bus.iomem_wstrb; hold_wdata = bus.iomem_wdata;
      end
      prev_v = bus.iomem_valid;
      if (done) begin
        done_cyc = c; err_at_done = error; busy_at_done = busy; cnt_at_done = count;
        break;
      end
    end
    start = 1'b0;
    if (done_cyc < 0) chk("done_seen", 68'(0), 68'(1));
    @(negedge clk);
    chk("done_pulse_width", 68'(done), 68'(0));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    resetn = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    wait_n = 1; rand_wait = 1'b0; stall_addr = 32'h0000_0001;
    repeat (2) @(negedge clk);
    chk("rst_busy", 68'(busy), 68'(0));
    chk("rst_done", 68'(done), 68'(0));
    chk("rst_error", 68'(error), 68'(0));
    chk("rst_count", 68'(count), 68'(0));
    chk("rst_valid", 68'(bus.iomem_valid), 68'(0));
    chk("rst_addr", 68'(bus.iomem_addr), 68'(0));
    chk("rst_state", 68'(dbg_state), 68'(ST_IDLE));
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // len == 0
    run_job(32'h0300_0000, 32'h0300_0010, LEN_W'(0), 0);
    chk("len0_done_cyc", 68'(done_cyc), 68'(1));
    chk("len0_valid_cycles", 68'(vcnt), 68'(0));
    chk("len0_busy_seen", 68'(busy_seen), 68'(0));
    chk("len0_count", 68'(cnt_at_done), 68'(0));
    check_log();

    // 3-word copy, registered responder
    push_copy(32'h0300_0000, 32'h0300_0010, 3);
    run_job(32'h0300_0000, 32'h0300_0010, LEN_W'(3), 0);
    chk("copy3_first_busy", 68'(first_busy), 68'(1));
    chk("copy3_first_valid", 68'(first_valid), 68'(1));
    chk("copy3_done_cyc", 68'(done_cyc), 68'(19));
    chk("copy3_valid_cycles", 68'(vcnt), 68'(12));
    chk("copy3_count", 68'(cnt_at_done), 68'(3));
    chk("copy3_error", 68'(err_at_done), 68'(0));
    chk("copy3_busy_at_done", 68'(busy_at_done), 68'(0));
    check_log();

    // timeout on the second read
    stall_addr = 32'h0300_0044;
    push_copy(32'h0300_0040, 32'h0300_0080, 1);
    run_job(32'h0300_0040, 32'h0300_0080, LEN_W'(3), 0);
    chk("tmo_done_cyc", 68'(done_cyc), 68'(15));
    chk("tmo_valid_cycles", 68'(vcnt), 68'(12));
    chk("tmo_error", 68'(err_at_done), 68'(1));
    chk("tmo_count", 68'(cnt_at_done), 68'(1));
    check_log();
    stall_addr = 32'h0000_0001;

    // address wrap with unaligned source
    exp_q.push_back({4'h0, 32'hFFFF_FFFC, 32'h0});
    exp_q.push_back({4'hF, 32'h0000_1000, pat(32'hFFFF_FFFC)});
    exp_q.push_back({4'h0, 32'h0000_0000, 32'h0});
    exp_q.push_back({4'hF, 32'h0000_1004, pat(32'h0000_0000)});
    run_job(32'hFFFF_FFFE, 32'h0000_1002, LEN_W'(2), 0);
    chk("wrap_done_cyc", 68'(done_cyc), 68'(13));
    chk("wrap_count", 68'(cnt_at_done), 68'(2));
    check_log();

    // random waits with a start injected mid-job
    rand_wait = 1'b1;
    push_copy(32'h0300_0100, 32'h0300_0200, 4);
    run_job(32'h0300_0100, 32'h0300_0203, LEN_W'(4), 5);
    chk("rand_count", 68'(cnt_at_done), 68'(4));
    chk("rand_error", 68'(err_at_done), 68'(0));
    check_log();
    rand_wait = 1'b0;

    // reset asserted during the second write
    wait_n = 3;
    @(negedge clk);
    start = 1'b1; src_addr = 32'h0300_0300; dst_addr = 32'h0300_0400; len = LEN_W'(2);
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (dbg_state == ST_WR && count == LEN_W'(1)) break;
      @(negedge clk);
    end
    chk("rst_mid_reached_wr", 68'(dbg_state), 68'(ST_WR));
    #2 resetn = 1'b0;
    #1;
    chk("rst_mid_busy", 68'(busy), 68'(0));
    chk("rst_mid_count", 68'(count), 68'(0));
    chk("rst_mid_valid", 68'(bus.iomem_valid), 68'(0));
    chk("rst_mid_wstrb", 68'(bus.iomem_wstrb), 68'(0));
    chk("rst_mid_addr", 68'(bus.iomem_addr), 68'(0));
    chk("rst_mid_wdata", 68'(bus.iomem_wdata), 68'(0));
    chk("rst_mid_done_err", 68'({done, error}), 68'(0));
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    exp_q.delete();
    rd_ptr = obs_n;
    wait_n = 1;
    repeat (2) @(negedge clk);
    push_copy(32'h0300_0500, 32'h0300_0600, 1);
    run_job(32'h0300_0500, 32'h0300_0600, LEN_W'(1), 0);
    chk("post_rst_done_cyc", 68'(done_cyc), 68'(7));
    chk("post_rst_count", 68'(cnt_at_done), 68'(1));
    check_log();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/iomem_dma.md
# iomem_dma

Word-copy engine that acts as an initiator on the picosoc iomem bus, the opposite end of the memory-mapped peripheral responders on that bus. On a start command it reads `len` 32-bit words from a source address and writes each to a destination address, one transaction at a time. It reports completion, a completed-word count, and a timeout error. It sits in the top level beside the SoC and shares the iomem responders with the CPU through an external arbiter.

## Interface

Parameters:
- `LEN_W`, 16, width of the length and count fields, in words.
- `TIMEOUT_CYCLES`, 255, the number of consecutive cycles with `iomem_valid` high and `iomem_ready` low that constitutes a timeout. Minimum value is 1.

Ports:
- `clk`  in  1  — single clock.
- `resetn`  in  1  — reset, asynchronous, active-low.
- `start`  in  1  — one-cycle command strobe. Sampled only in IDLE.
- `src_addr`  in  32  — source byte address. Bits [1:0] are ignored.
- `dst_addr`  in  32  — destination byte address. Bits [1:0] are ignored.
- `len`  in  `LEN_W`  — number of words to copy.
- `busy`  out  1  — high from the cycle after an accepted `start` until `done`.
- `done`  out  1  — one-cycle completion pulse.
- `error`  out  1  — one-cycle pulse, coincident with `done`, on timeout.
- `count`  out  `LEN_W`  — words fully copied in the current or last job.
- `iomem_valid`  out  1  — transaction request.
- `iomem_ready`  in  1  — responder acknowledge.
- `iomem_wstrb`  out  4  — write strobes. 0 means a read.
- `iomem_addr`  out  32  — word-aligned address.
- `iomem_wdata`  out  32  — write data.
- `iomem_rdata`  in  32  — read data. Valid when `iomem_ready` is high.

## Operation

- All outputs are registered. Reset values: every output is 0, and the FSM is in IDLE.
- FSM states: IDLE, RD, RGAP, WR, WGAP, FIN.
- IDLE:
  - `start` with `len` != 0: latch `src_addr & ~3`, `dst_addr & ~3` and `len`; clear `count`; go to RD.
  - `start` with `len` == 0: go to FIN with no bus traffic.
- RD: drive `iomem_valid`=1, `iomem_wstrb`=0, `iomem_addr`=src. When `iomem_ready` is sampled high, capture `iomem_rdata` into the word buffer and go to RGAP.
- RGAP: `iomem_valid`=0 for exactly one cycle, then go to WR.
- WR: drive `iomem_valid`=1, `iomem_wstrb`=4'hF, `iomem_addr`=dst, `iomem_wdata`=buffer. When `iomem_ready` is sampled high:
  - increment `count`;
  - add 4 to both src and dst, modulo 2^32 (wrap from 0xFFFFFFFC to 0 is legal);
  - go to WGAP.
- WGAP: one idle cycle. Then go to FIN if `count` == `len`, otherwise to RD.
- FIN: `done`=1 for one cycle, `busy`=0, then go to IDLE.
- Bus rule: `iomem_addr`, `iomem_wstrb` and `iomem_wdata` are stable while `iomem_valid` is high. `iomem_valid` never drops before `iomem_ready` is seen, except on timeout.
- Timeout:
  - The wait counter clears on entry to RD or WR and increments each cycle in RD or WR with `iomem_ready` low.
  - When it reaches `TIMEOUT_CYCLES`, drop `iomem_valid` and go to FIN with `error`=1.
  - `count` holds the number of completed words. A read that timed out does not count.
- `start` while `busy` is ignored, and latched parameters are unaffected.
- `iomem_ready` outside RD and WR is ignored.
- `resetn` asserted mid-job: outputs return to reset values immediately. No `done` pulse is produced.

## Timing

- `start` sampled in cycle 0 → `busy` and `iomem_valid` high in cycle 1.
- Transaction cost is 1 request cycle + responder wait + 1 gap cycle.
- With a responder whose `ready` is registered (ready one cycle after valid), each word takes 6 cycles.
- Final write's `ready` in cycle N → `done` in cycle N+2, after WGAP. `busy` is low in that same cycle.
- `len` == 0 → `done` in cycle 1, `busy` never rises.
- Timeout fires with `TIMEOUT_CYCLES` ready-less cycles after request entry. `done`/`error` appear the following cycle.

## Structure

- Shared package: the state enum, `WSTRB_READ` = 4'h0, `WSTRB_WORD` = 4'hF, and `WORD_BYTES` = 4.
- One sub-module: `iomem_dma_timer`, the wait counter with clear/enable inputs and an `expired` output, parameterised by `TIMEOUT_CYCLES`.

## Test plan

- Copy 3 words from 0x03000000 to 0x03000010 with a 1-cycle-ready responder model → 6 alternating reads/writes; each valid lasts 1 cycle plus the ready cycle; `done` at cycle 19; `count`=3; destination memory matches source.
- `len`=0 with `start` → `done`=1 in cycle 1; `iomem_valid` never high; `count`=0.
- Responder never asserts ready on the second read, `TIMEOUT_CYCLES`=8 → valid held for exactly 8 cycles; then `done`=`error`=1; `count`=1.
- `src_addr`=0xFFFFFFFE, `len`=2 → read addresses 0xFFFFFFFC then 0x00000000.
- Random responder wait of 0–5 cycles and a `start` pulse injected mid-job → stable addr/wdata while valid; second `start` ignored; final `count`=`len`.
- `resetn` low during a WR → all outputs 0 asynchronously; a new job after release completes normally.
